color_layer_scheduler: RTL and testbench
========================================

Name: color_layer_scheduler

Overview:
- Per-pixel scheduler for the shared 3-bit palette index that feeds the RGB palette lookup in the VGA output path.
- Arbitrates NUM_LAYERS drawing layers (cursor, sprites, board, background) by fixed priority.
- Applies frame-based flash gating and palette rotation, and forces the background colour during blanking.
- Two-stage pipeline, advancing only on the pixel-rate enable.

Parameters:
NUM_LAYERS, 4, number of requesting layers; layer 0 has highest priority
FLASH_FRAMES, 15, frames per flash half-period (1..255)
BG_COLOR, 3, palette index emitted when no layer hits or during blanking (3 = black)

Ports:
CLOCK  in  1  system clock
RESET  in  1  synchronous, active-high reset
pix_en  in  1  pixel strobe; pipeline and counters advance only when 1
frame_start  in  1  first pixel of frame; qualified by pix_en
in_blank  in  1  current pixel is in the blanking region
layer_valid  in  NUM_LAYERS  layer i requests the current pixel
layer_color  in  3*NUM_LAYERS  palette index of layer i, at bits [3i+2:3i]
layer_flash  in  NUM_LAYERS  layer i is subject to flash gating
cycle_en  in  1  enables palette rotation
color_out  out  3  palette index sent to the palette lookup
blank_out  out  1  in_blank delayed to align with color_out
hit  out  1  some layer won the pixel
active_layer  out  2  index of the winning layer (0 when hit=0)
flash_phase  out  1  current flash phase

Behaviour:
- Reset (synchronous, CLOCK edge with RESET=1) takes priority over pix_en. Reset values:
  - color_out=BG_COLOR, blank_out=1, hit=0, active_layer=0, flash_phase=0
  - frame counter=0, rot_offset=0
  - all pipeline registers cleared to the blank/background state
- pix_en=0: every register holds.
- Frame state, on a strobe with frame_start=1:
  - if frame_cnt==FLASH_FRAMES-1: frame_cnt becomes 0, flash_phase toggles, and rot_offset increments by 1 mod 8 when cycle_en=1.
  - otherwise frame_cnt increments.
  - frame_start on consecutive strobes: each one counts.
- Stage 1, on each strobe: registers layer_valid, layer_color, layer_flash and in_blank, together with the next-state flash_phase and rot_offset. The frame_start pixel therefore already uses the new frame state.
- Stage 2, on each strobe:
  - eff_valid[i] = valid[i] & ~(flash[i] & phase).
  - Winner is the lowest i with eff_valid[i]=1.
  - If blank: color_out=BG_COLOR, hit=0, active_layer=0.
  - Else if no winner: color_out=BG_COLOR, hit=0.
  - Else: color_out=(color[winner]+rot) mod 8 (3-bit wrap), hit=1, active_layer=winner.
  - blank_out is the stage-1 blank flag.
- Latency: exactly 2 pix_en strobes from input sampling to output; outputs change only on strobe edges.
- Rotation applies only to layer colours, never to BG_COLOR.
- cycle_en=0 freezes rot_offset at its current value; it does not clear it.
- RESET asserted mid-frame: outputs reach the reset values on the same edge. The next frame_start restarts counting from frame_cnt=0.
- frame_start while pix_en=0 is ignored.

Decomposition:
- Shared video package holds:
  - palette index constants (PURPLE=0, WHITE=1, BLUE=2, BLACK=3, TURQUOISE=4, YELLOW=5, GREEN=6, RED=7)
  - COLOR_W=3 and the layer-count constant
- Sub-module layer_priority_sel: combinational lowest-index-wins selector returning hit and index.
- The frame counter and flash/rotation logic stay inline.

Test Plan:
- Reset: hold RESET 2 cycles with random inputs -> color_out=3, blank_out=1, hit=0, flash_phase=0. After release with pix_en=0 throughout, outputs hold the reset values.
- Priority: layer_valid=4'b1010, layer_color={L3=7, L2=x, L1=5, L0=x}, in_blank=0, pix_en every cycle -> 2 strobes later color_out=5, active_layer=1, hit=1. With layer_valid=0 -> color_out=3, hit=0.
- Flash: FLASH_FRAMES=2, layer 0 valid with colour 6 and layer_flash[0]=1, layer 1 valid with colour 2.
  - Frames 0-1: color_out=6.
  - Frame 2 (phase=1): color_out=2, active_layer=1.
  - Frame 4: color_out=6 again.
- Rotation: cycle_en=1, FLASH_FRAMES=1, layer colour 7. Successive frames give color_out 0,1,2,... (frame 0 already gives 0, since rotation applies on the frame_start pixel). Background pixels stay 3.
- Blank and stall: in_blank=1 with valid layers -> color_out=3, hit=0, blank_out=1 after 2 strobes. With pix_en=1 only every 4th cycle, latency counts strobes, and outputs are stable between strobes.
- Reset mid-frame: RESET during frame 5 with flash_phase=1 and rot=3 -> next cycle phase=0, rot=0. The following frame_start gives frame_cnt=1.

Source files
------------

// File: rtl/color_layer_scheduler_pkg.sv
// Shared video definitions for the colour path.
// Holds the palette index names, palette index width, default layer count
// and the record types used by the layer scheduler pipeline.
package color_layer_scheduler_pkg;

    localparam int COLOR_W        = 3;
    localparam int NUM_LAYERS_DEF = 4;
    localparam int FRAME_CNT_W    = 8;

    typedef enum logic [COLOR_W-1:0] {
        PURPLE    = 3'd0,
        WHITE     = 3'd1,
        BLUE      = 3'd2,
        BLACK     = 3'd3,
        TURQUOISE = 3'd4,
        YELLOW    = 3'd5,
        GREEN     = 3'd6,
        RED       = 3'd7
    } color_e;

    // Frame-level state shared by every pixel of a frame.
    typedef struct packed {
        logic [FRAME_CNT_W-1:0] cnt;
        logic                   phase;
        logic [COLOR_W-1:0]     rot;
    } frame_state_t;

    // Registered pixel result presented to the palette lookup.
    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic               blank;
        logic               hit;
        logic [1:0]         layer;
    } pix_out_t;

endpackage

// File: rtl/color_layer_scheduler_priority_sel.sv
// layer_priority_sel: combinational fixed-priority selector.
// Ports: req (one bit per layer), hit (any request), idx (lowest requesting
// index, 0 when nothing requests).
module layer_priority_sel #(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_LAYERS-1:0] req,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);

    // Scan from the top down so the lowest index is the last writer and wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/color_layer_scheduler.sv
// color_layer_scheduler: per-pixel palette index scheduler for the VGA path.
// Ports:
//   CLOCK, RESET            clock and synchronous active-high reset
//   pix_en                  pixel strobe, all state advances only on it
//   frame_start             first pixel of a frame (qualified by pix_en)
//   in_blank                pixel lies in the blanking region
//   layer_valid/color/flash per-layer request, palette index, flash enable
//   cycle_en                enables palette rotation at frame wrap
//   color_out, blank_out    palette index and aligned blank flag
//   hit, active_layer       winning layer information
//   flash_phase             current flash phase
// Two-stage pipeline: stage 1 captures the pixel plus frame state, stage 2
// resolves priority/flash/rotation into the registered outputs.
module color_layer_scheduler
    import color_layer_scheduler_pkg::*;
#(
    parameter int                 NUM_LAYERS   = NUM_LAYERS_DEF,
    parameter int                 FLASH_FRAMES = 15,
    parameter logic [COLOR_W-1:0] BG_COLOR     = BLACK
) (
    input  logic                          CLOCK,
    input  logic                          RESET,
    input  logic                          pix_en,
    input  logic                          frame_start,
    input  logic                          in_blank,
    input  logic [NUM_LAYERS-1:0]         layer_valid,
    input  logic [COLOR_W*NUM_LAYERS-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]         layer_flash,
    input  logic                          cycle_en,
    output logic [COLOR_W-1:0]            color_out,
    output logic                          blank_out,
    output logic                          hit,
    output logic [1:0]                    active_layer,
    output logic                          flash_phase
);

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    frame_state_t frame_q, frame_d;

    logic [NUM_LAYERS-1:0]         s1_valid_q, s1_valid_d;
    logic [COLOR_W*NUM_LAYERS-1:0] s1_color_q, s1_color_d;
    logic [NUM_LAYERS-1:0]         s1_flash_q, s1_flash_d;
    logic                          s1_blank_q, s1_blank_d;
    logic                          s1_phase_q, s1_phase_d;
    logic [COLOR_W-1:0]            s1_rot_q,   s1_rot_d;

    pix_out_t out_q, out_d;

    logic [NUM_LAYERS-1:0] eff_valid;
    logic                  sel_hit;
    logic [IDX_W-1:0]      sel_idx;

    // Frame state: next value as it would be after this strobe.
    always_comb begin
        frame_d = frame_q;
        if (frame_start) begin
            if (frame_q.cnt == FRAME_CNT_W'(FLASH_FRAMES - 1)) begin
                frame_d.cnt   = '0;
                frame_d.phase = ~frame_q.phase;
                if (cycle_en) frame_d.rot = frame_q.rot + 1'b1;
            end else begin
                frame_d.cnt = frame_q.cnt + 1'b1;
            end
        end
    end

    // Stage 1 takes the post-update frame state so the frame_start pixel
    // is already drawn with the new phase and rotation.
    always_comb begin
        s1_valid_d = layer_valid;
        s1_color_d = layer_color;
        s1_flash_d = layer_flash;
        s1_blank_d = in_blank;
        s1_phase_d = frame_d.phase;
        s1_rot_d   = frame_d.rot;
    end

    assign eff_valid = s1_valid_q & ~(s1_flash_q & {NUM_LAYERS{s1_phase_q}});

    layer_priority_sel #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (IDX_W)
    ) u_sel (
        .req (eff_valid),
        .hit (sel_hit),
        .idx (sel_idx)
    );

    // Stage 2: rotation touches layer colours only, never the background.
    always_comb begin
        out_d.color = BG_COLOR;
        out_d.blank = s1_blank_q;
        out_d.hit   = 1'b0;
        out_d.layer = 2'd0;
        if (!s1_blank_q && sel_hit) begin
            out_d.color = s1_color_q[int'(sel_idx)*COLOR_W +: COLOR_W] + s1_rot_q;
            out_d.hit   = 1'b1;
            out_d.layer = 2'(sel_idx);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            frame_q    <= '0;
            s1_valid_q <= '0;
            s1_color_q <= '0;
            s1_flash_q <= '0;
            s1_blank_q <= 1'b1;
            s1_phase_q <= 1'b0;
            s1_rot_q   <= '0;
            out_q      <= '{color: BG_COLOR, blank: 1'b1, hit: 1'b0, layer: 2'd0};
        end else if (pix_en) begin
            frame_q    <= frame_d;
            s1_valid_q <= s1_valid_d;
            s1_color_q <= s1_color_d;
            s1_flash_q <= s1_flash_d;
            s1_blank_q <= s1_blank_d;
            s1_phase_q <= s1_phase_d;
            s1_rot_q   <= s1_rot_d;
            out_q      <= out_d;
        end
    end

    assign color_out    = out_q.color;
    assign blank_out    = out_q.blank;
    assign hit          = out_q.hit;
    assign active_layer = out_q.layer;
    assign flash_phase  = frame_q.phase;

endmodule

// File: tb/tb_color_layer_scheduler.sv
// Bench for color_layer_scheduler. Two instances share the stimulus:
// dut_a with FLASH_FRAMES=2 and dut_b with FLASH_FRAMES=1.
module tb_color_layer_scheduler;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        pix_en = 1'b0;
    logic        frame_start = 1'b0;
    logic        in_blank = 1'b0;
    logic [3:0]  layer_valid = '0;
    logic [11:0] layer_color = '0;
    logic [3:0]  layer_flash = '0;
    logic        cycle_en = 1'b0;

    logic [2:0] col_a, col_b;
    logic       blk_a, blk_b, hit_a, hit_b, ph_a, ph_b;
    logic [1:0] lay_a, lay_b;

    int checks = 0;
    int errors = 0;
    bit chk_model = 0;

    always #5 CLOCK = ~CLOCK;

    color_layer_scheduler #(.NUM_LAYERS(4), .FLASH_FRAMES(2), .BG_COLOR(3'd3)) dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .pix_en(pix_en), .frame_start(frame_start),
        .in_blank(in_blank), .layer_valid(layer_valid), .layer_color(layer_color),
        .layer_flash(layer_flash), .cycle_en(cycle_en), .color_out(col_a),
        .blank_out(blk_a), .hit(hit_a), .active_layer(lay_a), .flash_phase(ph_a));

    color_layer_scheduler #(.NUM_LAYERS(4), .FLASH_FRAMES(1), .BG_COLOR(3'd3)) dut_b (
        .CLOCK(CLOCK), .RESET(RESET), .pix_en(pix_en), .frame_start(frame_start),
        .in_blank(in_blank), .layer_valid(layer_valid), .layer_color(layer_color),
        .layer_flash(layer_flash), .cycle_en(cycle_en), .color_out(col_b),
        .blank_out(blk_b), .hit(hit_b), .active_layer(lay_b), .flash_phase(ph_b));

    // ---------------- reference model ----------------
    typedef struct {int color; int blank; int hit; int layer;} exp_t;

    int   m_cnt[2], m_phase[2], m_rot[2];
    exp_t m_s1[2], m_out[2];
    int   ff_of[2] = '{2, 1};

    function automatic exp_t bg_pix(int blank);
        exp_t e;
        e.color = 3; e.blank = blank; e.hit = 0; e.layer = 0;
        return e;
    endfunction

    function automatic exp_t eval(logic bl, logic [3:0] v, logic [11:0] c,
                                  logic [3:0] f, int ph, int rot);
        exp_t e;
        e = bg_pix(int'(bl));
        if (!bl) begin
            for (int i = 0; i < 4; i++) begin
                if (v[i] && !(f[i] && ph == 1)) begin
                    e.color = (int'(c[3*i +: 3]) + rot) % 8;
                    e.hit   = 1;
                    e.layer = i;
                    break;
                end
            end
        end
        return e;
    endfunction

    task automatic model_step(logic rst, logic pen, logic fs, logic bl, logic [3:0] v,
                              logic [11:0] c, logic [3:0] f, logic cyc);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_cnt[k] = 0; m_phase[k] = 0; m_rot[k] = 0;
                m_s1[k] = bg_pix(1); m_out[k] = bg_pix(1);
            end else if (pen) begin
                if (fs) begin
                    if (m_cnt[k] == ff_of[k] - 1) begin
                        m_cnt[k] = 0;
                        m_phase[k] = 1 - m_phase[k];
                        if (cyc) m_rot[k] = (m_rot[k] + 1) % 8;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
                m_out[k] = m_s1[k];
                m_s1[k]  = eval(bl, v, c, f, m_phase[k], m_rot[k]);
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("rnd_col_a", int'(col_a), m_out[0].color);
        chk("rnd_blk_a", int'(blk_a), m_out[0].blank);
        chk("rnd_hit_a", int'(hit_a), m_out[0].hit);
        chk("rnd_lay_a", int'(lay_a), m_out[0].layer);
        chk("rnd_ph_a",  int'(ph_a),  m_phase[0]);
        chk("rnd_col_b", int'(col_b), m_out[1].color);
        chk("rnd_blk_b", int'(blk_b), m_out[1].blank);
        chk("rnd_hit_b", int'(hit_b), m_out[1].hit);
        chk("rnd_lay_b", int'(lay_b), m_out[1].layer);
        chk("rnd_ph_b",  int'(ph_b),  m_phase[1]);
    endtask

    // One clock: inputs already driven, sample #1 after the edge.
    task automatic tick();
        logic rst, pen, fs, bl, cyc;
        logic [3:0] v, f;
        logic [11:0] c;
        rst = RESET; pen = pix_en; fs = frame_start; bl = in_blank;
        v = layer_valid; c = layer_color; f = layer_flash; cyc = cycle_en;
        @(posedge CLOCK);
        #1;
        model_step(rst, pen, fs, bl, v, c, f, cyc);
        if (chk_model) compare_model();
    endtask

    task automatic do_reset();
        RESET = 1'b1; pix_en = 1'b1; frame_start = 1'b0; tick();
        RESET = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1; tick();
        frame_start = 1'b0;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [3:0] v; logic [11:0] c; logic [3:0] f; logic bl;
        int ec; int eh; int el;
    } vec_t;
    vec_t tbl[6];

    initial begin
        tbl[0] = '{4'b1010, {3'd7, 3'd1, 3'd5, 3'd2}, 4'b0000, 1'b0, 5, 1, 1};
        tbl[1] = '{4'b0000, {3'd7, 3'd1, 3'd5, 3'd2}, 4'b0000, 1'b0, 3, 0, 0};
        tbl[2] = '{4'b1000, {3'd7, 3'd1, 3'd5, 3'd2}, 4'b0000, 1'b0, 7, 1, 3};
        tbl[3] = '{4'b1111, {3'd1, 3'd2, 3'd5, 3'd4}, 4'b0000, 1'b0, 4, 1, 0};
        tbl[4] = '{4'b1111, {3'd1, 3'd2, 3'd5, 3'd4}, 4'b0000, 1'b1, 3, 0, 0};
        tbl[5] = '{4'b0100, {3'd1, 3'd6, 3'd5, 3'd4}, 4'b0100, 1'b0, 6, 1, 2};

        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            RESET = 1'b1; pix_en = 1'($urandom); frame_start = 1'($urandom);
            in_blank = 1'($urandom); layer_valid = 4'($urandom);
            layer_color = 12'($urandom); cycle_en = 1'($urandom);
            tick();
        end
        chk("rst_color", int'(col_a), 3); chk("rst_blank", int'(blk_a), 1);
        chk("rst_hit", int'(hit_a), 0);   chk("rst_layer", int'(lay_a), 0);
        chk("rst_phase", int'(ph_a), 0);  chk("rst_phase_b", int'(ph_b), 0);
        RESET = 1'b0; pix_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame_start = 1'($urandom); layer_valid = 4'($urandom);
            layer_color = 12'($urandom); in_blank = 1'b0; cycle_en = 1'b1;
            tick();
        end
        chk("hold_color", int'(col_a), 3); chk("hold_blank", int'(blk_a), 1);
        chk("hold_hit", int'(hit_b), 0);   chk("hold_phase_b", int'(ph_b), 0);

        // Table vectors: no frame_start, so phase=0 and rot=0.
        cycle_en = 1'b0; do_reset();
        for (int i = 0; i < 6; i++) begin
            layer_valid = tbl[i].v; layer_color = tbl[i].c;
            layer_flash = tbl[i].f; in_blank = tbl[i].bl; pix_en = 1'b1;
            tick(); tick();
            chk($sformatf("tbl%0d_color", i), int'(col_a), tbl[i].ec);
            chk($sformatf("tbl%0d_hit", i), int'(hit_a), tbl[i].eh);
            chk($sformatf("tbl%0d_layer", i), int'(lay_a), tbl[i].el);
            chk($sformatf("tbl%0d_blank", i), int'(blk_a), int'(tbl[i].bl));
        end

        // Flash gating: L0=6 flashing, L1=2 steady.
        in_blank = 1'b0; cycle_en = 1'b0; do_reset();
        layer_valid = 4'b0011; layer_color = {3'd0, 3'd0, 3'd2, 3'd6}; layer_flash = 4'b0001;
        tick(); tick();
        chk("flash_f0_a", int'(col_a), 6);
        for (int f = 1; f <= 4; f++) begin
            frame_pulse(); tick();
            chk($sformatf("flash_f%0d_a", f), int'(col_a), (f == 2 || f == 3) ? 2 : 6);
            chk($sformatf("flash_f%0d_la", f), int'(lay_a), (f == 2 || f == 3) ? 1 : 0);
            chk($sformatf("flash_f%0d_b", f), int'(col_b), (f % 2 == 1) ? 2 : 6);
        end

        // Rotation: colour 7 on layer 0, cycle_en on.
        cycle_en = 1'b1; do_reset();
        layer_valid = 4'b0001; layer_color = {3'd0, 3'd0, 3'd0, 3'd7}; layer_flash = 4'b0000;
        for (int f = 1; f <= 9; f++) begin
            frame_pulse(); tick();
            chk($sformatf("rot_f%0d_b", f), int'(col_b), (7 + f) % 8);
            chk($sformatf("rot_f%0d_a", f), int'(col_a), (7 + f / 2) % 8);
            if (f == 3) begin
                layer_valid = 4'b0000; tick(); tick();
                chk("rot_bg_b", int'(col_b), 3);
                layer_valid = 4'b0001;
            end
        end

        // Stall: strobe every 4th cycle.
        cycle_en = 1'b0; do_reset();
        layer_valid = 4'b0010; layer_color = {3'd0, 3'd0, 3'd5, 3'd0}; in_blank = 1'b0;
        pix_en = 1'b1; tick();
        chk("stall_s1_color", int'(col_a), 3);
        pix_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            layer_valid = 4'($urandom); layer_color = 12'($urandom); in_blank = 1'($urandom);
            tick();
            chk("stall_gap1_color", int'(col_a), 3);
        end
        layer_valid = 4'b0001; layer_color = {3'd0, 3'd0, 3'd0, 3'd1}; in_blank = 1'b1;
        pix_en = 1'b1; tick();
        chk("stall_s2_color", int'(col_a), 5); chk("stall_s2_hit", int'(hit_a), 1);
        pix_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            layer_valid = 4'($urandom); frame_start = 1'($urandom); tick();
            chk("stall_gap2_color", int'(col_a), 5); chk("stall_gap2_blank", int'(blk_a), 0);
        end
        frame_start = 1'b0; pix_en = 1'b1; tick();
        chk("stall_s3_color", int'(col_a), 3); chk("stall_s3_blank", int'(blk_a), 1);
        chk("stall_s3_hit", int'(hit_a), 0);
        chk("stall_fs_ignored", int'(ph_b), 0);

        // Reset mid-frame.
        cycle_en = 1'b1; in_blank = 1'b0; do_reset();
        layer_valid = 4'b0001; layer_color = {3'd0, 3'd0, 3'd0, 3'd7};
        frame_pulse(); frame_pulse(); frame_pulse();
        chk("mid_pre_phase_b", int'(ph_b), 1);
        chk("mid_pre_phase_a", int'(ph_a), 1);
        RESET = 1'b1; tick(); RESET = 1'b0;
        chk("mid_rst_phase_b", int'(ph_b), 0); chk("mid_rst_color", int'(col_b), 3);
        cycle_en = 1'b0; tick(); tick();
        chk("mid_rot_cleared", int'(col_b), 7);
        frame_pulse();
        chk("mid_cnt_restart", int'(ph_a), 0);
        frame_pulse();
        chk("mid_cnt_wrap", int'(ph_a), 1);

        // Randomized against the reference model.
        do_reset();
        chk_model = 1;
        for (int i = 0; i < 3000; i++) begin
            RESET       = ($urandom_range(0, 199) == 0);
            pix_en      = ($urandom_range(0, 9) < 7);
            frame_start = ($urandom_range(0, 9) == 0);
            in_blank    = ($urandom_range(0, 5) == 0);
            layer_valid = 4'($urandom); layer_color = 12'($urandom);
            layer_flash = 4'($urandom); cycle_en = ($urandom_range(0, 3) != 0);
            tick();
        end
        chk_model = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
